// File: rtl/id_ctrl_stage.sv
// ID stage of the pipeline: decodes the IF/ID instruction into a control word and
// registers it toward EX, with load-use bubbles, EX backpressure hold and flush.
module id_ctrl_stage #(
  parameter int REG_ADDR_W    = 5,
  parameter int ALU_OP_W      = 3,
  parameter int CNT_W         = 16,
  parameter bit ENABLE_HAZARD = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic                  valid_i,
  input  logic                  ex_ready_i,
  input  logic                  flush_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  output logic                  valid_o,
  output logic                  reg_write_o,
  output logic                  alu_src_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [1:0]            reg_dst_o,
  output logic [1:0]            mem_to_reg_o,
  output logic [1:0]            branch_type_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  illegal_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      decode_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic [ALU_OP_W-1:0]   aluOp;
    logic                  aluSrc;
    logic [1:0]            regDst;
    logic [1:0]            memToReg;
    logic                  branch;
    logic [1:0]            branchType;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  jump;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } ctrlWord_t;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rsField;
  logic [REG_ADDR_W-1:0] rtField;
  logic [REG_ADDR_W-1:0] rdField;
  logic                  rsUsed;
  logic                  rtUsed;
  logic                  hazard;
  logic                  cntInc;
  logic                  unusedLowBits;
  ctrlWord_t             decWord;
  ctrlWord_t             nextWord;
  ctrlWord_t             ctrlQ;

  assign opcode        = instr_i[31:26];
  assign rsField       = REG_ADDR_W'(instr_i[25:21]);
  assign rtField       = REG_ADDR_W'(instr_i[20:16]);
  assign rdField       = REG_ADDR_W'(instr_i[15:11]);
  assign unusedLowBits = ^instr_i[10:0];

  always_comb begin
    decWord       = '0;
    decWord.valid = 1'b1;
    decWord.rs    = rsField;
    decWord.rt    = rtField;
    decWord.rd    = rdField;
    rsUsed        = 1'b1;
    rtUsed        = 1'b0;
    case (opcode)
      6'b000000: begin
        decWord.regDst   = 2'b01;
        decWord.regWrite = 1'b1;
        rtUsed           = 1'b1;
      end
      6'b001000, 6'b001011, 6'b001111, 6'b001101: begin
        decWord.aluSrc   = 1'b1;
        decWord.regWrite = 1'b1;
        case (opcode[2:0])
          3'b000:  decWord.aluOp = ALU_OP_W'(3'd1);
          3'b011:  decWord.aluOp = ALU_OP_W'(3'd2);
          3'b111:  decWord.aluOp = ALU_OP_W'(3'd4);
          default: decWord.aluOp = ALU_OP_W'(3'd5);
        endcase
      end
      // beq/bne/ble carry their branch type in the opcode's low bits; bltz ignores rt
      6'b000100, 6'b000101, 6'b000110, 6'b000001: begin
        decWord.aluOp      = ALU_OP_W'(3'd3);
        decWord.branch     = 1'b1;
        decWord.branchType = (opcode == 6'b000001) ? 2'b11 : opcode[1:0];
        rtUsed             = (opcode != 6'b000001);
      end
      6'b100011: begin
        decWord.aluOp    = ALU_OP_W'(3'd1);
        decWord.aluSrc   = 1'b1;
        decWord.memToReg = 2'b01;
        decWord.regWrite = 1'b1;
        decWord.memRead  = 1'b1;
      end
      6'b101011: begin
        decWord.aluOp    = ALU_OP_W'(3'd1);
        decWord.aluSrc   = 1'b1;
        decWord.memWrite = 1'b1;
        rtUsed           = 1'b1;
      end
      6'b000010: begin
        decWord.aluOp = ALU_OP_W'(3'd7);
        decWord.jump  = 1'b1;
        rsUsed        = 1'b0;
      end
      6'b000011: begin
        decWord.regDst   = 2'b10;
        decWord.memToReg = 2'b11;
        decWord.regWrite = 1'b1;
        decWord.jump     = 1'b1;
        rsUsed           = 1'b0;
      end
      default: decWord.illegal = 1'b1;
    endcase
  end

  assign hazard = ENABLE_HAZARD && valid_i && ex_mem_read_i && (ex_rt_i != '0) &&
                  ((rsUsed && (ex_rt_i == rsField)) || (rtUsed && (ex_rt_i == rtField)));

  assign stall_o = ~flush_i & (hazard | ~ex_ready_i);

  // Flush beats backpressure, which beats the load-use bubble; a bubble is an all-zero word.
  always_comb begin
    nextWord = ctrlQ;
    cntInc   = 1'b0;
    if (flush_i) begin
      nextWord = '0;
    end else if (!ex_ready_i) begin
      nextWord = ctrlQ;
    end else if (hazard) begin
      nextWord = '0;
    end else if (valid_i) begin
      nextWord = decWord;
      cntInc   = 1'b1;
    end else begin
      nextWord    = '0;
      nextWord.rs = rsField;
      nextWord.rt = rtField;
      nextWord.rd = rdField;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrlQ        <= '0;
      decode_cnt_o <= '0;
    end else begin
      ctrlQ <= nextWord;
      if (cntInc && (decode_cnt_o != '1)) begin
        decode_cnt_o <= decode_cnt_o + 1'b1;
      end
    end
  end

  assign valid_o       = ctrlQ.valid;
  assign alu_op_o      = ctrlQ.aluOp;
  assign alu_src_o     = ctrlQ.aluSrc;
  assign reg_dst_o     = ctrlQ.regDst;
  assign mem_to_reg_o  = ctrlQ.memToReg;
  assign branch_o      = ctrlQ.branch;
  assign branch_type_o = ctrlQ.branchType;
  assign reg_write_o   = ctrlQ.regWrite;
  assign mem_read_o    = ctrlQ.memRead;
  assign mem_write_o   = ctrlQ.memWrite;
  assign jump_o        = ctrlQ.jump;
  assign illegal_o     = ctrlQ.illegal;
  assign rs_o          = ctrlQ.rs;
  assign rt_o          = ctrlQ.rt;
  assign rd_o          = ctrlQ.rd;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: two instances (default, and hazard-off with a 4-bit counter)
// driven by shared stimulus and compared every cycle against a table-driven model.
module tb_id_ctrl_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] instr;
  logic        valid;
  logic        exReady;
  logic        flush;
  logic        exMemRead;
  logic [4:0]  exRt;

  logic       oValid[2], oRegWrite[2], oAluSrc[2], oBranch[2], oJump[2];
  logic       oMemRead[2], oMemWrite[2], oIllegal[2], oStall[2];
  logic [2:0] oAluOp[2];
  logic [1:0] oRegDst[2], oMemToReg[2], oBranchType[2];
  logic [4:0] oRs[2], oRt[2], oRd[2];
  logic [15:0] cntA;
  logic [3:0]  cntB;

  id_ctrl_stage dutA (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .valid_i(valid), .ex_ready_i(exReady),
    .flush_i(flush), .ex_mem_read_i(exMemRead), .ex_rt_i(exRt),
    .valid_o(oValid[0]), .reg_write_o(oRegWrite[0]), .alu_src_o(oAluSrc[0]),
    .branch_o(oBranch[0]), .jump_o(oJump[0]), .mem_read_o(oMemRead[0]),
    .mem_write_o(oMemWrite[0]), .alu_op_o(oAluOp[0]), .reg_dst_o(oRegDst[0]),
    .mem_to_reg_o(oMemToReg[0]), .branch_type_o(oBranchType[0]), .rs_o(oRs[0]),
    .rt_o(oRt[0]), .rd_o(oRd[0]), .illegal_o(oIllegal[0]), .stall_o(oStall[0]),
    .decode_cnt_o(cntA)
  );

  id_ctrl_stage #(.CNT_W(4), .ENABLE_HAZARD(1'b0)) dutB (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .valid_i(valid), .ex_ready_i(exReady),
    .flush_i(flush), .ex_mem_read_i(exMemRead), .ex_rt_i(exRt),
    .valid_o(oValid[1]), .reg_write_o(oRegWrite[1]), .alu_src_o(oAluSrc[1]),
    .branch_o(oBranch[1]), .jump_o(oJump[1]), .mem_read_o(oMemRead[1]),
    .mem_write_o(oMemWrite[1]), .alu_op_o(oAluOp[1]), .reg_dst_o(oRegDst[1]),
    .mem_to_reg_o(oMemToReg[1]), .branch_type_o(oBranchType[1]), .rs_o(oRs[1]),
    .rt_o(oRt[1]), .rd_o(oRd[1]), .illegal_o(oIllegal[1]), .stall_o(oStall[1]),
    .decode_cnt_o(cntB)
  );

  typedef struct {
    bit legal;
    int aluOp; bit aluSrc; int regDst; int memToReg; bit branch; int branchType;
    bit regWrite; bit memRead; bit memWrite; bit jump; bit rtUsed;
  } row_t;

  typedef struct {
    bit valid;
    int aluOp; bit aluSrc; int regDst; int memToReg; bit branch; int branchType;
    bit regWrite; bit memRead; bit memWrite; bit jump; bit illegal;
    int rs; int rt; int rd; int cnt;
  } word_t;

  row_t  tbl[64];
  word_t m[2];
  bit    hazEn[2]  = '{1'b1, 1'b0};
  int    cntMax[2] = '{65535, 15};
  bit    modelKnown = 1'b0;
  bit    stallSeen[2];
  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    legalOps[14] = '{0, 8, 11, 15, 13, 4, 5, 6, 1, 35, 43, 2, 3, 63};

  task automatic setRow(input int opc, input int aOp, input bit aSrc, input int rDst,
                        input int m2r, input bit br, input int bt, input bit rw,
                        input bit mr, input bit mw, input bit j, input bit rtU);
    tbl[opc] = '{1'b1, aOp, aSrc, rDst, m2r, br, bt, rw, mr, mw, j, rtU};
  endtask

  function automatic logic [31:0] mk(input int opc, input int rs, input int rt, input int rd);
    return {opc[5:0], rs[4:0], rt[4:0], rd[4:0], 11'h2a5};
  endfunction

  function automatic bit hazRef(input int k);
    int opc = int'(instr[31:26]);
    bit rsU = !(opc == 2 || opc == 3);
    return hazEn[k] && valid && exMemRead && (exRt != 0) &&
           ((rsU && exRt == instr[25:21]) || (tbl[opc].rtUsed && exRt == instr[20:16]));
  endfunction

  function automatic word_t bubble(input word_t w);
    word_t b = '{default: 0};
    b.cnt = w.cnt;
    return b;
  endfunction

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      if (rst) m[k] = '{default: 0};
      else if (flush) m[k] = bubble(m[k]);
      else if (!exReady) m[k] = m[k];
      else if (hazRef(k) || !valid) m[k] = bubble(m[k]);
      else begin
        row_t r = tbl[int'(instr[31:26])];
        m[k] = '{1'b1, r.aluOp, r.aluSrc, r.regDst, r.memToReg, r.branch, r.branchType,
                 r.regWrite, r.memRead, r.memWrite, r.jump, !r.legal,
                 int'(instr[25:21]), int'(instr[20:16]), int'(instr[15:11]),
                 (m[k].cnt < cntMax[k]) ? m[k].cnt + 1 : m[k].cnt};
      end
    end
    modelKnown = 1'b1;
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d actual %0h required %0h", nm, k, cycle, act, exp);
    end
  endtask

  // Registered outputs are compared with the model state from the previous edge; stall with the current inputs.
  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      stallSeen[k] = oStall[k];
      chk("stall", k, 32'(oStall[k]), 32'(!flush && (hazRef(k) || !exReady)));
      if (modelKnown) begin
        chk("valid", k, 32'(oValid[k]), 32'(m[k].valid));
        chk("illegal", k, 32'(oIllegal[k]), 32'(m[k].illegal));
        chk("aluOp", k, 32'(oAluOp[k]), 32'(m[k].aluOp));
        chk("aluSrc", k, 32'(oAluSrc[k]), 32'(m[k].aluSrc));
        chk("regDst", k, 32'(oRegDst[k]), 32'(m[k].regDst));
        chk("memToReg", k, 32'(oMemToReg[k]), 32'(m[k].memToReg));
        chk("branch", k, 32'(oBranch[k]), 32'(m[k].branch));
        chk("branchType", k, 32'(oBranchType[k]), 32'(m[k].branchType));
        chk("regWrite", k, 32'(oRegWrite[k]), 32'(m[k].regWrite));
        chk("memRead", k, 32'(oMemRead[k]), 32'(m[k].memRead));
        chk("memWrite", k, 32'(oMemWrite[k]), 32'(m[k].memWrite));
        chk("jump", k, 32'(oJump[k]), 32'(m[k].jump));
        chk("cnt", k, (k == 0) ? 32'(cntA) : 32'(cntB), 32'(m[k].cnt));
        if (m[k].valid) begin
          chk("rs", k, 32'(oRs[k]), 32'(m[k].rs));
          chk("rt", k, 32'(oRt[k]), 32'(m[k].rt));
          chk("rd", k, 32'(oRd[k]), 32'(m[k].rd));
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [31:0] ins, input bit v, input bit rdy,
                               input bit fl, input bit mr, input logic [4:0] ert);
    rst = r; instr = ins; valid = v; exReady = rdy; flush = fl; exMemRead = mr; exRt = ert;
    #3;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    int cntBefore;
    int opc;
    for (int i = 0; i < 64; i++) tbl[i] = '{default: 0};
    setRow(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    setRow(8, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    setRow(11, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    setRow(15, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    setRow(13, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    setRow(4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    setRow(5, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    setRow(6, 3, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1);
    setRow(1, 3, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    setRow(35, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    setRow(43, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    setRow(2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    setRow(3, 0, 0, 2, 3, 0, 0, 1, 0, 0, 1, 0);

    // Reset with arbitrary inputs
    applyStimulus(1, $urandom, 1, 0, 0, 1, 5'd3);
    applyStimulus(1, $urandom, 1, 1, 1, 0, 5'd7);
    chk("rstValid", 0, 32'(oValid[0]), 0);
    chk("rstCnt", 0, 32'(cntA), 0);

    // Decode sweep
    foreach (legalOps[i]) begin
      applyStimulus(0, mk(legalOps[i], 9, 10, 11), 1, 1, 0, 0, 0);
      if (legalOps[i] == 3) begin
        chk("jalRegDst", 0, 32'(oRegDst[0]), 2);
        chk("jalMemToReg", 0, 32'(oMemToReg[0]), 3);
        chk("jalJump", 0, 32'(oJump[0]), 1);
        chk("jalRegWrite", 0, 32'(oRegWrite[0]), 1);
      end
      if (legalOps[i] == 63) begin
        chk("illFlag", 0, 32'(oIllegal[0]), 1);
        chk("illRegWrite", 0, 32'(oRegWrite[0]), 0);
      end
    end

    // Load-use: one bubble, then the dependent add loads
    cntBefore = int'(cntA);
    applyStimulus(0, mk(0, 8, 2, 3), 1, 1, 0, 1, 5'd8);
    chk("luStall", 0, 32'(stallSeen[0]), 1);
    chk("luNoHazStall", 1, 32'(stallSeen[1]), 0);
    chk("luBubble", 0, 32'(oValid[0]), 0);
    chk("luCntHeld", 0, 32'(cntA), 32'(cntBefore));
    applyStimulus(0, mk(0, 8, 2, 3), 1, 1, 0, 0, 5'd8);
    chk("luLoad", 0, 32'(oValid[0]), 1);
    chk("luCntStep", 0, 32'(cntA), 32'(cntBefore + 1));
    applyStimulus(0, mk(0, 0, 2, 3), 1, 1, 0, 1, 5'd0);
    chk("luZeroRt", 0, 32'(stallSeen[0]), 0);

    // Backpressure while ori is held
    applyStimulus(0, mk(13, 4, 5, 6), 1, 1, 0, 0, 0);
    cntBefore = int'(cntA);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, mk(8, 1, 2, 3), 1, 0, 0, 0, 0);
      chk("bpStall", 0, 32'(stallSeen[0]), 1);
      chk("bpAluOp", 0, 32'(oAluOp[0]), 5);
      chk("bpCnt", 0, 32'(cntA), 32'(cntBefore));
    end

    // Flush beats hazard and backpressure
    applyStimulus(0, mk(8, 1, 2, 3), 1, 1, 0, 0, 0);
    applyStimulus(0, mk(0, 9, 2, 3), 1, 0, 1, 1, 5'd9);
    chk("flStall", 0, 32'(stallSeen[0]), 0);
    chk("flBubble", 0, 32'(oValid[0]), 0);

    // Counter saturation on the 4-bit instance
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, mk(8, 1, 2, 3), 1, 1, 0, 0, 0);
    chk("satB", 1, 32'(cntB), 15);
    chk("satA", 0, 32'(cntA), 20);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      opc = ($urandom_range(7) == 0) ? int'($urandom_range(63)) : legalOps[$urandom_range(13)];
      applyStimulus($urandom_range(63) == 0,
                    mk(opc, $urandom_range(7), $urandom_range(7), $urandom_range(31)),
                    $urandom_range(7) != 0, $urandom_range(3) != 0,
                    $urandom_range(7) == 0, $urandom_range(2) == 0,
                    5'($urandom_range(7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
